// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: next-PC select, hold buffering, misalignment trap, retire count.
// Optional 16-bit instruction support is enabled by defining PC_SEQ_RVC_EN.
module pc_sequencer #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0040_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0040_0100,
    parameter int               CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             cond_jump,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             is_compressed,
    input  logic             commit,
    input  logic             hold,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             fetch_valid,
    output logic             misalign_trap,
    output logic [XLEN-1:0]  trap_pc,
    output logic [XLEN-1:0]  trap_tval,
    output logic [CNT_W-1:0] retired
);
    localparam logic [6:0] OP_B_TYPE    = 7'b1100011;
    localparam logic [6:0] OP_J_TYPE    = 7'b1101111;
    localparam logic [6:0] OP_JALR_TYPE = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pend_q;
    logic [XLEN-1:0]   trap_pc_q;
    logic [XLEN-1:0]   trap_tval_q;
    logic [CNT_W-1:0]  retired_q;
    logic              fetch_valid_q;
    logic              misalign_trap_q;

    logic [XLEN-1:0]   inc_s;
    logic [XLEN-1:0]   pc_plus_inc_s;
    logic [XLEN-1:0]   target_s;
    logic              misaligned_s;

`ifndef PC_SEQ_RVC_EN
    logic unused_compressed_s;
    assign unused_compressed_s = is_compressed;
`endif

    // Instruction length, link value, next-target selection and alignment check.
    always_comb begin
`ifdef PC_SEQ_RVC_EN
        if (is_compressed) begin
            inc_s = XLEN'(2);
        end else begin
            inc_s = XLEN'(4);
        end
`else
        inc_s = XLEN'(4);
`endif
        pc_plus_inc_s = pc_q + inc_s;
        case (opcode)
            OP_B_TYPE:    target_s = cond_jump ? alu_out : pc_plus_inc_s;
            OP_J_TYPE:    target_s = alu_out;
            OP_JALR_TYPE: target_s = {alu_out[XLEN-1:1], 1'b0};
            default:      target_s = pc_plus_inc_s;
        endcase
`ifdef PC_SEQ_RVC_EN
        misaligned_s = target_s[0];
`else
        misaligned_s = |target_s[1:0];
`endif
    end

    // Sequencer FSM; fetch_valid and misalign_trap are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            pc_q            <= RESET_VECTOR;
            pend_q          <= '0;
            trap_pc_q       <= '0;
            trap_tval_q     <= '0;
            retired_q       <= '0;
            fetch_valid_q   <= 1'b0;
            misalign_trap_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (commit && misaligned_s) begin
                        // Hold is deliberately ignored: the trap takes priority.
                        state_q         <= ST_TRAP;
                        pc_q            <= TRAP_VECTOR;
                        trap_pc_q       <= pc_q;
                        trap_tval_q     <= target_s;
                        fetch_valid_q   <= 1'b0;
                        misalign_trap_q <= 1'b1;
                    end else if (commit && !hold) begin
                        pc_q          <= target_s;
                        retired_q     <= retired_q + CNT_W'(1);
                        fetch_valid_q <= 1'b1;
                    end else if (commit) begin
                        state_q       <= ST_PEND;
                        pend_q        <= target_s;
                        retired_q     <= retired_q + CNT_W'(1);
                        fetch_valid_q <= 1'b0;
                    end else begin
                        fetch_valid_q <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (!hold) begin
                        state_q       <= ST_RUN;
                        pc_q          <= pend_q;
                        fetch_valid_q <= 1'b1;
                    end else begin
                        fetch_valid_q <= 1'b0;
                    end
                end
                ST_TRAP: begin
                    if (resume) begin
                        state_q         <= ST_RUN;
                        fetch_valid_q   <= 1'b1;
                        misalign_trap_q <= 1'b0;
                    end else begin
                        fetch_valid_q   <= 1'b0;
                        misalign_trap_q <= 1'b1;
                    end
                end
                default: begin
                    state_q         <= ST_RUN;
                    fetch_valid_q   <= 1'b0;
                    misalign_trap_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc            = pc_q;
    assign pc_plus_inc   = pc_plus_inc_s;
    assign fetch_valid   = fetch_valid_q;
    assign misalign_trap = misalign_trap_q;
    assign trap_pc       = trap_pc_q;
    assign trap_tval     = trap_tval_q;
    assign retired       = retired_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan steps plus random traffic against a behavioural model.
module tb_pc_sequencer;
    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] TV = 32'h0040_0100;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_R = 7'b0110011;

    logic clk = 1'b0;
    logic rst_n, cond_jump, is_compressed, commit, hold, resume;
    logic [6:0] opcode;
    logic [31:0] alu_out;
    logic [31:0] pc, pc_plus_inc, trap_pc, trap_tval, retired;
    logic fetch_valid, misalign_trap;

    logic rst2_n, commit2;
    logic [31:0] pc2, ppi2, tpc2, tval2;
    logic fv2, mt2;
    logic [3:0] retired2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [31:0] m_pc, m_pending, m_tpc, m_tval, m_ret;
    bit m_fv, m_in_pend, m_in_trap;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond_jump(cond_jump),
        .alu_out(alu_out), .is_compressed(is_compressed), .commit(commit),
        .hold(hold), .resume(resume), .pc(pc), .pc_plus_inc(pc_plus_inc),
        .fetch_valid(fetch_valid), .misalign_trap(misalign_trap),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .retired(retired)
    );

    pc_sequencer #(.CNT_W(4)) dut_cnt (
        .clk(clk), .rst_n(rst2_n), .opcode(OP_R), .cond_jump(1'b0),
        .alu_out(32'h0000_0000), .is_compressed(1'b0), .commit(commit2),
        .hold(1'b0), .resume(1'b0), .pc(pc2), .pc_plus_inc(ppi2),
        .fetch_valid(fv2), .misalign_trap(mt2), .trap_pc(tpc2),
        .trap_tval(tval2), .retired(retired2)
    );

    function automatic logic [31:0] inst_len();
`ifdef PC_SEQ_RVC_EN
        return is_compressed ? 32'd2 : 32'd4;
`else
        return 32'd4;
`endif
    endfunction

    function automatic bit is_misaligned(logic [31:0] t);
`ifdef PC_SEQ_RVC_EN
        return (t % 32'd2) != 32'd0;
`else
        return (t % 32'd4) != 32'd0;
`endif
    endfunction

    function automatic logic [31:0] next_target();
        logic [31:0] seq;
        seq = m_pc + inst_len();
        if (opcode == OP_B) return cond_jump ? alu_out : seq;
        if (opcode == OP_J) return alu_out;
        if (opcode == OP_JALR) return alu_out & 32'hFFFF_FFFE;
        return seq;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model from the inputs presented before the coming edge.
    task automatic model_update();
        logic [31:0] t;
        if (!rst_n) begin
            m_pc = RV; m_pending = 32'd0; m_tpc = 32'd0; m_tval = 32'd0; m_ret = 32'd0;
            m_fv = 1'b0; m_in_pend = 1'b0; m_in_trap = 1'b0;
        end else if (m_in_trap) begin
            if (resume) m_in_trap = 1'b0;
            m_fv = !m_in_trap;
        end else if (m_in_pend) begin
            if (!hold) begin
                m_pc = m_pending;
                m_in_pend = 1'b0;
            end
            m_fv = !m_in_pend;
        end else begin
            if (commit) begin
                t = next_target();
                if (is_misaligned(t)) begin
                    m_tpc = m_pc; m_tval = t; m_pc = TV; m_in_trap = 1'b1;
                end else begin
                    m_ret = m_ret + 32'd1;
                    if (hold) begin
                        m_pending = t; m_in_pend = 1'b1;
                    end else begin
                        m_pc = t;
                    end
                end
            end
            m_fv = !(m_in_pend || m_in_trap);
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("pc_plus_inc", pc_plus_inc, m_pc + inst_len());
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
        chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_in_trap});
        chk("trap_pc", trap_pc, m_tpc);
        chk("trap_tval", trap_tval, m_tval);
        chk("retired", retired, m_ret);
    endtask

    task automatic drive(bit c, logic [6:0] op, logic [31:0] a, bit cj, bit h);
        commit = c; opcode = op; alu_out = a; cond_jump = cj; hold = h;
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; commit2 = 1'b0; resume = 1'b0; is_compressed = 1'b0;
        drive(1'b0, OP_R, 32'd0, 1'b0, 1'b0);
        m_pc = RV; m_pending = 32'd0; m_tpc = 32'd0; m_tval = 32'd0; m_ret = 32'd0;
        m_fv = 1'b0; m_in_pend = 1'b0; m_in_trap = 1'b0;

        // Reset then release with commit low.
        tick(); tick();
        chk("reset_fv", {31'd0, fetch_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("release_fv", {31'd0, fetch_valid}, 32'd1);
        tick(); tick();
        chk("release_pc", pc, RV);
        chk("release_retired", retired, 32'd0);

        // Five sequential commits.
        drive(1'b1, OP_R, 32'd0, 1'b0, 1'b0);
        repeat (5) tick();
        chk("seq5_pc", pc, 32'h0040_0014);
        chk("seq5_retired", retired, 32'd5);

        // Branch taken, not taken, JALR with bit 0 set.
        drive(1'b1, OP_B, 32'h0040_0200, 1'b1, 1'b0); tick();
        chk("b_taken", pc, 32'h0040_0200);
        drive(1'b1, OP_B, 32'h0040_0200, 1'b0, 1'b0); tick();
        chk("b_not_taken", pc, 32'h0040_0204);
        drive(1'b1, OP_JALR, 32'h0040_0301, 1'b0, 1'b0); tick();
        chk("jalr", pc, 32'h0040_0300);
        chk("jalr_no_trap", {31'd0, misalign_trap}, 32'd0);

        // Jump held for three cycles.
        drive(1'b1, OP_J, 32'h0040_0400, 1'b0, 1'b1); tick();
        commit = 1'b0;
        tick(); tick();
        chk("pend_pc", pc, 32'h0040_0300);
        chk("pend_fv", {31'd0, fetch_valid}, 32'd0);
        hold = 1'b0; tick();
        chk("pend_release_pc", pc, 32'h0040_0400);
        chk("pend_retired", retired, 32'd9);

        // Misaligned jump from 0x0040_0010.
        drive(1'b1, OP_J, 32'h0040_0010, 1'b0, 1'b0); tick();
        drive(1'b1, OP_J, 32'h0040_0022, 1'b0, 1'b1); tick();
`ifdef PC_SEQ_RVC_EN
        chk("rvc_accept", pc, 32'h0040_0022);
        is_compressed = 1'b1;
        drive(1'b1, OP_R, 32'd0, 1'b0, 1'b0); tick();
        chk("rvc_seq", pc, 32'h0040_0024);
        is_compressed = 1'b0;
        commit = 1'b0; hold = 1'b0; tick();
`else
        chk("trap_flag", {31'd0, misalign_trap}, 32'd1);
        chk("trap_pc_vec", pc, TV);
        chk("trap_pc_saved", trap_pc, 32'h0040_0010);
        chk("trap_tval_saved", trap_tval, 32'h0040_0022);
        chk("trap_retired", retired, 32'd10);
        drive(1'b1, OP_R, 32'd0, 1'b0, 1'b0); tick();
        chk("trap_commit_ignored", retired, 32'd10);
        commit = 1'b0; resume = 1'b1; tick();
        resume = 1'b0;
        chk("resume_fv", {31'd0, fetch_valid}, 32'd1);
`endif

        // Reset during PEND discards the pending target.
        drive(1'b1, OP_J, 32'h0040_0500, 1'b0, 1'b1); tick();
        rst_n = 1'b0; commit = 1'b0; hold = 1'b0; tick();
        rst_n = 1'b1; tick(); tick();
        chk("rst_pend_pc", pc, RV);
        chk("rst_pend_retired", retired, 32'd0);

        // Reset during TRAP.
        drive(1'b1, OP_J, 32'h0040_0003, 1'b0, 1'b0); tick();
        chk("trap_again", {31'd0, misalign_trap}, 32'd1);
        commit = 1'b0; rst_n = 1'b0; tick();
        chk("rst_trap_flag", {31'd0, misalign_trap}, 32'd0);
        chk("rst_trap_tval", trap_tval, 32'd0);
        rst_n = 1'b1; tick();

        // Address wrap at the top of the space.
        drive(1'b1, OP_J, 32'hFFFF_FFFC, 1'b0, 1'b0); tick();
        drive(1'b1, OP_R, 32'd0, 1'b0, 1'b0); tick();
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_no_trap", {31'd0, misalign_trap}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            opcode = (sel == 2'd0) ? OP_B : (sel == 2'd1) ? OP_J : (sel == 2'd2) ? OP_JALR : OP_R;
            alu_out = $urandom();
            if ($urandom_range(0, 3) != 0) alu_out = alu_out & 32'hFFFF_FFFC;
            cond_jump = 1'($urandom_range(0, 1));
            is_compressed = 1'($urandom_range(0, 1));
            commit = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 2) == 0);
            resume = ($urandom_range(0, 4) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
        end
        rst_n = 1'b1; commit = 1'b0; resume = 1'b0; hold = 1'b0;

        // 4-bit retire counter wraps after 16 commits.
        @(negedge clk); rst2_n = 1'b0;
        @(negedge clk); rst2_n = 1'b1;
        @(negedge clk); commit2 = 1'b1;
        repeat (14) @(negedge clk);
        chk("cnt_14", {28'd0, retired2}, 32'd14);
        repeat (2) @(negedge clk);
        commit2 = 1'b0;
        chk("cnt_wrap", {28'd0, retired2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
